// File: rtl/cpu_mem_bridge_if.sv
// SDRAM channel between the CPU bridge and the SDRAM controller.
// master: request side (bridge) - drives sdr_req/addr/wr/be/wdata.
// slave : controller side        - drives sdr_ack/sdr_rdata.
interface cpu_mem_bridge_if;
  logic        sdr_req;
  logic        sdr_ack;
  logic [24:0] sdr_req_addr;
  logic        sdr_wr;
  logic [1:0]  sdr_be;
  logic [15:0] sdr_wdata;
  logic [15:0] sdr_rdata;

  modport master (
    output sdr_req, sdr_req_addr, sdr_wr, sdr_be, sdr_wdata,
    input  sdr_ack, sdr_rdata
  );

  modport slave (
    input  sdr_req, sdr_req_addr, sdr_wr, sdr_be, sdr_wdata,
    output sdr_ack, sdr_rdata
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// CPU bus cycle to SDRAM toggle-handshake bridge with a one-word read cache.
// Ports:
//   clk_sys, reset_n      clock, synchronous active-low reset
//   cpu_mrd/cpu_mwr       CPU read/write strobes (level, whole bus cycle)
//   cpu_be, cpu_dout      byte enables and write data from the CPU
//   cpu_din, cpu_ready    read data and registered ready (low = stall)
//   ram_rom_memrq         cycle targets RAM/ROM (from the translator)
//   writable, sdr_addr    region write permission and byte address
//   sdr                   SDRAM channel (req/ack toggle pair + payload)
module cpu_mem_bridge #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_mrd,
  input  logic        cpu_mwr,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_ready,
  input  logic        ram_rom_memrq,
  input  logic        writable,
  input  logic [24:0] sdr_addr,
  cpu_mem_bridge_if.master sdr
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = AW - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t          state_q,       state_d;
  logic            strobe_q,      strobe_d;
  logic            ready_q,       ready_d;
  logic [DW-1:0]   din_q,         din_d;
  logic            req_q,         req_d;
  logic [AW-1:0]   addr_q,        addr_d;
  logic            wr_q,          wr_d;
  logic [1:0]      be_q,          be_d;
  logic [DW-1:0]   wdata_q,       wdata_d;
  logic            cache_valid_q, cache_valid_d;
  logic [TW-1:0]   cache_tag_q,   cache_tag_d;
  logic [DW-1:0]   cache_data_q,  cache_data_d;

  logic strobe;
  logic start;
  logic cache_hit;
  logic ack_seen;

  assign strobe    = cpu_mrd | cpu_mwr;
  assign start     = strobe & ~strobe_q;
  assign cache_hit = CACHE_EN && cache_valid_q && (cache_tag_q == sdr_addr[AW-1:1]);
  assign ack_seen  = (sdr.sdr_ack == req_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    strobe_d      = strobe;
    ready_d       = ready_q;
    din_d         = din_q;
    req_d         = req_q;
    addr_d        = addr_q;
    wr_d          = wr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && ram_rom_memrq) begin
          if (cpu_mwr && !writable) begin
            // Write to a read-only region: dropped, CPU not stalled.
          end else if (!cpu_mwr && cache_hit) begin
            din_d = cache_data_q;
          end else begin
            addr_d  = sdr_addr & ~AW'(1);
            wr_d    = cpu_mwr;
            be_d    = cpu_be;
            wdata_d = cpu_dout;
            req_d   = ~req_q;
            ready_d = 1'b0;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (ack_seen) begin
          if (!wr_q) begin
            din_d         = sdr.sdr_rdata;
            cache_valid_d = 1'b1;
            cache_tag_d   = addr_q[AW-1:1];
            cache_data_d  = sdr.sdr_rdata;
          end else if (cache_valid_q && (cache_tag_q == addr_q[AW-1:1])) begin
            // Keep the cached copy coherent with the written bytes.
            if (be_q[0]) cache_data_d[7:0]  = wdata_q[7:0];
            if (be_q[1]) cache_data_d[15:8] = wdata_q[15:8];
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        ready_d = 1'b1;
        // Wait for the strobe to drop so one CPU cycle yields one request.
        if (!strobe) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      strobe_q      <= 1'b0;
      ready_q       <= 1'b1;
      din_q         <= '0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      strobe_q      <= strobe_d;
      ready_q       <= ready_d;
      din_q         <= din_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end

  assign cpu_din          = din_q;
  assign cpu_ready        = ready_q;
  assign sdr.sdr_req      = req_q;
  assign sdr.sdr_req_addr = addr_q;
  assign sdr.sdr_wr       = wr_q;
  assign sdr.sdr_be       = be_q;
  assign sdr.sdr_wdata    = wdata_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: a CPU-side driver, a toggle-ack
// SDRAM model, and a word-level reference memory plus cache-tag model.
module tb_cpu_mem_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpu_mrd, cpu_mwr;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        cpu_ready;
  logic        ram_rom_memrq, writable;
  logic [24:0] sdr_addr;

  always #5 clk_sys = ~clk_sys;

  cpu_mem_bridge_if sdr_if();

  cpu_mem_bridge #(.CACHE_EN(1'b1)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .cpu_mrd       (cpu_mrd),
    .cpu_mwr       (cpu_mwr),
    .cpu_be        (cpu_be),
    .cpu_dout      (cpu_dout),
    .cpu_din       (cpu_din),
    .cpu_ready     (cpu_ready),
    .ram_rom_memrq (ram_rom_memrq),
    .writable      (writable),
    .sdr_addr      (sdr_addr),
    .sdr           (sdr_if)
  );

  int errors = 0;
  int checks = 0;
  int unsigned ack_delay = 5;

  // sdram: contents as seen by the controller model (written from DUT outputs).
  // ref_mem: expected contents, written only from the CPU stimulus.
  logic [15:0] sdram   [int unsigned];
  logic [15:0] ref_mem [int unsigned];
  bit          m_valid = 1'b0;
  int unsigned m_tag   = 0;
  logic [15:0] exp_din = 16'h0;

  function automatic logic [15:0] dflt(input int unsigned w);
    return 16'((w * 32'd40503) ^ 32'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(input int unsigned w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return dflt(w);
  endfunction

  // SDRAM controller: acks ack_delay cycles after it first sees a new toggle.
  initial begin : sdram_model
    int unsigned cnt;
    int unsigned w;
    logic [15:0] v;
    cnt = 0;
    sdr_if.sdr_ack   = 1'b0;
    sdr_if.sdr_rdata = 16'h0;
    forever begin
      @(posedge clk_sys); #1;
      if (!reset_n) begin
        sdr_if.sdr_ack = 1'b0;
        cnt = 0;
      end else if (sdr_if.sdr_req !== sdr_if.sdr_ack) begin
        cnt++;
        if (cnt > ack_delay) begin
          w = 32'(sdr_if.sdr_req_addr[24:1]);
          v = sdram.exists(w) ? sdram[w] : dflt(w);
          if (sdr_if.sdr_wr) begin
            if (sdr_if.sdr_be[0]) v[7:0]  = sdr_if.sdr_wdata[7:0];
            if (sdr_if.sdr_be[1]) v[15:8] = sdr_if.sdr_wdata[15:8];
            sdram[w] = v;
          end else begin
            sdr_if.sdr_rdata = v;
          end
          sdr_if.sdr_ack = sdr_if.sdr_req;
          cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys); #2;
  endtask

  // One CPU bus cycle; predicts hit/miss/drop/ignore from the model and
  // checks cycle-level behaviour against it.
  task automatic access(input bit is_wr, input logic [24:0] a, input logic [1:0] be,
                        input logic [15:0] dout, input bit wrbl, input bit mrq,
                        input bit early_drop, input string name);
    int unsigned w;
    int          kind;  // 0 ignore, 1 hit, 2 drop, 3 request
    int          n;
    logic        req0;
    logic [15:0] exp_rd;
    logic [15:0] nv;
    w = 32'(a[24:1]);
    if (!mrq)       kind = 0;
    else if (is_wr) kind = wrbl ? 3 : 2;
    else            kind = (m_valid && m_tag == w) ? 1 : 3;
    exp_rd = ref_rd(w);
    req0   = sdr_if.sdr_req;

    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL %0s start_while_busy: ready=%b need 1", name, cpu_ready);
    end

    sdr_addr = a; cpu_be = be; cpu_dout = dout; writable = wrbl;
    ram_rom_memrq = mrq; cpu_mrd = !is_wr; cpu_mwr = is_wr;
    tick();  // T+1

    if (kind != 3) begin
      if (kind == 1) exp_din = exp_rd;
      checks++;
      if (sdr_if.sdr_req !== req0 || cpu_ready !== 1'b1 || cpu_din !== exp_din) begin
        errors++;
        $display("FAIL %0s no_req: req=%b ready=%b din=%h need req=%b ready=1 din=%h",
                 name, sdr_if.sdr_req, cpu_ready, cpu_din, req0, exp_din);
      end
      cpu_mrd = 1'b0; cpu_mwr = 1'b0;
      tick();
      return;
    end

    checks++;
    if (sdr_if.sdr_req !== ~req0 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL %0s issue: req=%b ready=%b need req=%b ready=0",
               name, sdr_if.sdr_req, cpu_ready, ~req0);
    end
    n = 0;
    while (n < 100) begin
      checks++;
      if (sdr_if.sdr_req_addr !== {a[24:1], 1'b0} || sdr_if.sdr_wr !== is_wr ||
          sdr_if.sdr_be !== be || sdr_if.sdr_wdata !== dout || cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL %0s payload: addr=%h wr=%b be=%b wd=%h rdy=%b need %h %b %b %h 0",
                 name, sdr_if.sdr_req_addr, sdr_if.sdr_wr, sdr_if.sdr_be,
                 sdr_if.sdr_wdata, cpu_ready, {a[24:1], 1'b0}, is_wr, be, dout);
      end
      if (sdr_if.sdr_ack === sdr_if.sdr_req) break;
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %0s ack_timeout: waited %0d cycles", name, n);
    end
    // Cycle A: ack toggle visible.
    if (early_drop) begin cpu_mrd = 1'b0; cpu_mwr = 1'b0; end
    tick();  // A+1
    if (!is_wr) exp_din = exp_rd;
    checks++;
    if (cpu_ready !== 1'b0 || cpu_din !== exp_din) begin
      errors++;
      $display("FAIL %0s complete: ready=%b din=%h need ready=0 din=%h",
               name, cpu_ready, cpu_din, exp_din);
    end
    tick();  // A+2
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL %0s ready_rise: ready=%b need 1", name, cpu_ready);
    end
    cpu_mrd = 1'b0; cpu_mwr = 1'b0;
    tick(); tick();
    checks++;
    if (sdr_if.sdr_req !== ~req0 || cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL %0s one_toggle: req=%b ready=%b need req=%b ready=1",
               name, sdr_if.sdr_req, cpu_ready, ~req0);
    end

    if (!is_wr) begin
      m_valid = 1'b1; m_tag = w;
    end else begin
      nv = exp_rd;
      if (be[0]) nv[7:0]  = dout[7:0];
      if (be[1]) nv[15:8] = dout[15:8];
      ref_mem[w] = nv;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (cpu_ready !== 1'b1 || cpu_din !== 16'h0 || sdr_if.sdr_req !== 1'b0 ||
        sdr_if.sdr_req_addr !== 25'h0 || sdr_if.sdr_wr !== 1'b0 ||
        sdr_if.sdr_be !== 2'b00 || sdr_if.sdr_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b din=%h req=%b addr=%h wr=%b be=%b wd=%h need 1 0 0 0 0 0 0",
               cpu_ready, cpu_din, sdr_if.sdr_req, sdr_if.sdr_req_addr,
               sdr_if.sdr_wr, sdr_if.sdr_be, sdr_if.sdr_wdata);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_miss();
    ack_delay = 5;
    access(1'b0, 25'h0_1234, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, "read_miss");
    checks++;
    if (cpu_din !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_miss_data: din=%h need beef", cpu_din);
    end
  endtask

  task automatic test_cache_hit();
    access(1'b0, 25'h0_1235, 2'b01, 16'h0, 1'b0, 1'b1, 1'b0, "cache_hit");
    checks++;
    if (cpu_din !== 16'hBEEF) begin
      errors++;
      $display("FAIL cache_hit_data: din=%h need beef", cpu_din);
    end
  endtask

  task automatic test_write_merge();
    access(1'b1, 25'h0_1234, 2'b01, 16'h0055, 1'b1, 1'b1, 1'b0, "write_merge");
    access(1'b0, 25'h0_1234, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, "merge_hit");
    checks++;
    if (cpu_din !== 16'hBE55) begin
      errors++;
      $display("FAIL merge_data: din=%h need be55", cpu_din);
    end
  endtask

  task automatic test_dropped_write();
    access(1'b1, 25'h0_1234, 2'b11, 16'hFFFF, 1'b0, 1'b1, 1'b0, "dropped_write");
    access(1'b0, 25'h0_1234, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, "after_drop_hit");
    checks++;
    if (cpu_din !== 16'hBE55) begin
      errors++;
      $display("FAIL after_drop_data: din=%h need be55", cpu_din);
    end
  endtask

  task automatic test_ignore();
    access(1'b0, 25'h0_0800, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0, "ignore_read");
    access(1'b1, 25'h0_1234, 2'b11, 16'h1111, 1'b1, 1'b0, 1'b0, "ignore_write");
    access(1'b0, 25'h0_1234, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, "after_ignore_hit");
  endtask

  task automatic test_ack_with_strobe_fall();
    ack_delay = 3;
    access(1'b0, 25'h1FF_FFFF, 2'b10, 16'h0, 1'b0, 1'b1, 1'b1, "early_drop_read");
    access(1'b0, 25'h1FF_FFFE, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, "top_word_hit");
  endtask

  task automatic test_reset_in_wait();
    ack_delay = 5;
    sdr_addr = 25'h0_2000; cpu_be = 2'b11; cpu_dout = 16'h0; writable = 1'b0;
    ram_rom_memrq = 1'b1; cpu_mrd = 1'b1; cpu_mwr = 1'b0;
    tick(); tick();
    reset_n = 1'b0; cpu_mrd = 1'b0;
    tick();
    checks++;
    if (cpu_ready !== 1'b1 || sdr_if.sdr_req !== 1'b0 || cpu_din !== 16'h0) begin
      errors++;
      $display("FAIL reset_in_wait: ready=%b req=%b din=%h need 1 0 0",
               cpu_ready, sdr_if.sdr_req, cpu_din);
    end
    reset_n = 1'b1;
    tick();
    m_valid = 1'b0; exp_din = 16'h0;
    access(1'b0, 25'h0_1234, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, "miss_after_reset");
    checks++;
    if (cpu_din !== 16'hBE55) begin
      errors++;
      $display("FAIL miss_after_reset_data: din=%h need be55", cpu_din);
    end
  endtask

  task automatic test_random();
    logic [24:0] pool [4];
    logic [24:0] a;
    pool[0] = 25'h0_1234; pool[1] = 25'h0_1236; pool[2] = 25'h1FF_FFFE; pool[3] = 25'h0_0000;
    for (int i = 0; i < 40; i++) begin
      ack_delay = $urandom_range(1, 6);
      a = pool[$urandom_range(0, 3)] | 25'($urandom_range(0, 1));
      access($urandom_range(0, 2) == 0, a, 2'($urandom_range(0, 3)),
             16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
             1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    reset_n = 1'b0; cpu_mrd = 1'b0; cpu_mwr = 1'b0; cpu_be = 2'b00;
    cpu_dout = 16'h0; ram_rom_memrq = 1'b0; writable = 1'b0; sdr_addr = 25'h0;
    sdram[32'h91A]   = 16'hBEEF;
    ref_mem[32'h91A] = 16'hBEEF;

    test_reset();
    test_read_miss();
    test_cache_hit();
    test_write_merge();
    test_dropped_write();
    test_ignore();
    test_ack_with_strobe_fall();
    test_reset_in_wait();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
